// File: rtl/alu_mdu_if.sv
// Request/response handshake bundle between the EX-stage issuer and alu_mdu.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_mdu.sv
// Multi-cycle ALU with optional RV32M iterative multiply/divide.
// Define ALU_MDU_MEXT_EN to compile in the MUL/DIV states; otherwise ops 0x10-0x17 return 0.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  alu_mdu_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

`ifdef ALU_MDU_MEXT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_e;
`else
  typedef enum logic {S_IDLE = 1'b0, S_DONE = 1'b1} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

`ifdef ALU_MDU_MEXT_EN
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [1:0]        mop_q, mop_d;
  logic [XLEN:0]     mul_sum_s, div_sh_s, div_trial_s;
  logic [2*XLEN-1:0] mul_nxt_s, div_nxt_s, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, a_mag_s, b_mag_s;
  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
`endif

  function automatic logic [XLEN-1:0] base_alu(input logic [4:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] r;
    logic            slt, ult;
    sh  = b[SHW-1:0];
    slt = $signed(a) < $signed(b);
    ult = a < b;
    r   = {XLEN{1'b0}};
    if (op[4] == 1'b0) begin
      case (op[3:0])
        4'h0:               r = a + b;
        4'h1, 4'hA, 4'hB:   r = a - b;
        4'h2:               r = a & b;
        4'h3:               r = a | b;
        4'h4:               r = a ^ b;
        4'h5:               r = a << sh;
        4'h6:               r = a >> sh;
        4'h7:               r = $signed(a) >>> sh;
        4'h8, 4'hC:         r = {{(XLEN-1){1'b0}}, slt};
        4'h9, 4'hE:         r = {{(XLEN-1){1'b0}}, ult};
        4'hD:               r = {{(XLEN-1){1'b0}}, ~slt};
        4'hF:               r = {{(XLEN-1){1'b0}}, ~ult};
        default:            r = {XLEN{1'b0}};
      endcase
    end else begin
      r = {XLEN{1'b0}};
    end
    return r;
  endfunction

  // Next-state, datapath iteration and registered-output computation.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_MDU_MEXT_EN
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    mop_d  = mop_q;
    // Shift-add step: the accumulator carries the multiplier in its low half.
    mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    mul_nxt_s = {mul_sum_s, acc_q[XLEN-1:1]};
    prod_s    = neg_q ? -mul_nxt_s : mul_nxt_s;
    div_sh_s    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial_s = div_sh_s - {1'b0, opnd_q};
    if (div_trial_s[XLEN]) begin
      div_nxt_s = {div_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_nxt_s = {div_trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    quo_s = neg_q ? -div_nxt_s[XLEN-1:0] : div_nxt_s[XLEN-1:0];
    rem_s = neg_q ? -div_nxt_s[2*XLEN-1:XLEN] : div_nxt_s[2*XLEN-1:XLEN];
    if (bus.op[2]) begin
      a_sgn_s = ~bus.op[0];
      b_sgn_s = ~bus.op[0];
    end else begin
      a_sgn_s = (bus.op[1:0] != 2'b11);
      b_sgn_s = ~bus.op[1];
    end
    a_neg_s = a_sgn_s & bus.a[XLEN-1];
    b_neg_s = b_sgn_s & bus.b[XLEN-1];
    a_mag_s = a_neg_s ? -bus.a : bus.a;
    b_mag_s = b_neg_s ? -bus.b : bus.b;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d  = S_DONE;
          result_d = base_alu(bus.op, bus.a, bus.b);
`ifdef ALU_MDU_MEXT_EN
          if (bus.op[4:3] == 2'b10) begin
            cnt_d = {SHW{1'b0}};
            mop_d = bus.op[1:0];
            if (!bus.op[2]) begin
              state_d = S_MUL;
              acc_d   = {{XLEN{1'b0}}, b_mag_s};
              opnd_d  = a_mag_s;
              neg_d   = a_neg_s ^ b_neg_s;
            end else if (bus.b == {XLEN{1'b0}}) begin
              result_d = bus.op[1] ? bus.a : ONES;
            end else if (!bus.op[0] && (bus.a == SMIN) && (bus.b == ONES)) begin
              result_d = bus.op[1] ? {XLEN{1'b0}} : bus.a;
            end else begin
              state_d = S_DIV;
              acc_d   = {{XLEN{1'b0}}, a_mag_s};
              opnd_d  = b_mag_s;
              neg_d   = bus.op[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
            end
          end else begin
            cnt_d = cnt_q;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_MDU_MEXT_EN
      S_MUL: begin
        acc_d = mul_nxt_s;
        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == SHW'(XLEN-1)) begin
          state_d  = S_DONE;
          result_d = (mop_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        acc_d = div_nxt_s;
        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == SHW'(XLEN-1)) begin
          state_d  = S_DONE;
          result_d = mop_q[1] ? rem_s : quo_s;
        end else begin
          state_d = S_DIV;
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    zero_d      = (result_d == {XLEN{1'b0}});
`ifdef ALU_MDU_MEXT_EN
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
`else
    busy_d = 1'b0;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= {XLEN{1'b0}};
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef ALU_MDU_MEXT_EN
      acc_q  <= {(2*XLEN){1'b0}};
      opnd_q <= {XLEN{1'b0}};
      cnt_q  <= {SHW{1'b0}};
      neg_q  <= 1'b0;
      mop_q  <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef ALU_MDU_MEXT_EN
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      mop_q  <= mop_d;
`endif
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed spec vectors plus randomized ops against a reference model.
`timescale 1ns/1ps
module tb_alu_mdu;
  localparam int XLEN = 32;
`ifdef ALU_MDU_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_mdu_if #(.XLEN(XLEN)) bus ();
  alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t dv [17] = '{
    '{5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000},
    '{5'h07, 32'h80000000, 32'h00000024, 32'hF8000000},
    '{5'h0F, 32'h00000001, 32'hFFFFFFFF, 32'h00000000},
    '{5'h0C, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
    '{5'h0E, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{5'h11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
    '{5'h13, 32'hFFFFFFFF, 32'h00000002, 32'h00000001},
    '{5'h12, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
    '{5'h10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE},
    '{5'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
    '{5'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
    '{5'h15, 32'h00000005, 32'h00000000, 32'hFFFFFFFF},
    '{5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
    '{5'h17, 32'h00000007, 32'h00000000, 32'h00000007},
    '{5'h15, 32'h00000064, 32'h00000007, 32'h0000000E},
    '{5'h1B, 32'h00000005, 32'h00000005, 32'h00000000}
  };

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 64'sd0;
    r  = 32'h0;
    if (op[4:3] == 2'b10 && !MEXT) return 32'h0;
    case (op)
      5'h00: r = a + b;
      5'h01, 5'h0A, 5'h0B: r = a - b;
      5'h02: r = a & b;
      5'h03: r = a | b;
      5'h04: r = a ^ b;
      5'h05: r = a << b[4:0];
      5'h06: r = a >> b[4:0];
      5'h07: r = $signed(a) >>> b[4:0];
      5'h08, 5'h0C: r = (sa < sb) ? 32'h1 : 32'h0;
      5'h09, 5'h0E: r = (ua < ub) ? 32'h1 : 32'h0;
      5'h0D: r = (sa >= sb) ? 32'h1 : 32'h0;
      5'h0F: r = (ua >= ub) ? 32'h1 : 32'h0;
      5'h10: begin p = sa * sb; r = p[31:0]; end
      5'h11: begin p = sa * sb; r = p[63:32]; end
      5'h12: begin p = sa * ub; r = p[63:32]; end
      5'h13: begin p = ua * ub; r = p[63:32]; end
      5'h14: r = (b == 32'h0) ? 32'hFFFFFFFF :
                 (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      5'h15: r = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      5'h16: r = (b == 32'h0) ? a :
                 (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
      5'h17: r = (b == 32'h0) ? a : a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!MEXT || op[4:3] != 2'b10) return 1;
    if (!op[2]) return 33;
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Issues one request, scrambles the inputs after acceptance, waits for the result and completes the handshake.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat, output int bcnt,
                        output logic rdy0, output logic drop);
    rdy0 = bus.in_ready;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 1;
    bcnt = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    z = bus.zero;
    @(posedge clk); #1;
    drop = (bus.out_valid === 1'b0) && (bus.in_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = 5'h0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.zero, bus.busy} !== 4'b0110) begin
      errors++;
      $display("FAIL reset_flags: got ov/ir/z/busy=%b expected 0110", {bus.out_valid, bus.in_ready, bus.zero, bus.busy});
    end
    checks++;
    if (bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 00000000", bus.result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] res, exp;
    logic z, rdy0, drop;
    int lat, bcnt;
    for (int i = 0; i < 17; i++) begin
      exp = (dv[i].op[4:3] == 2'b10 && !MEXT) ? 32'h0 : dv[i].r;
      run_op(dv[i].op, dv[i].a, dv[i].b, res, z, lat, bcnt, rdy0, drop);
      checks++;
      if (res !== exp || z !== (exp == 32'h0)) begin
        errors++;
        $display("FAIL directed_result[%0d] op=%h: got %h z=%b expected %h z=%b", i, dv[i].op, res, z, exp, exp == 32'h0);
      end
      checks++;
      if (lat != exp_lat(dv[i].op, dv[i].a, dv[i].b) || bcnt != ((lat == 33) ? 32 : 0)) begin
        errors++;
        $display("FAIL directed_latency[%0d] op=%h: got lat=%0d busy=%0d expected lat=%0d", i, dv[i].op, lat, bcnt, exp_lat(dv[i].op, dv[i].a, dv[i].b));
      end
      checks++;
      if (!rdy0 || !drop) begin
        errors++;
        $display("FAIL directed_handshake[%0d]: got ready_before=%b idle_after=%b expected 1 1", i, rdy0, drop);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, exp, a, b;
    logic [4:0] op;
    logic z, rdy0, drop;
    int lat, bcnt, el;
    for (int i = 0; i < 80; i++) begin
      op = 5'($urandom_range(0, 31));
      a = pick();
      b = pick();
      exp = model(op, a, b);
      el = exp_lat(op, a, b);
      run_op(op, a, b, res, z, lat, bcnt, rdy0, drop);
      checks++;
      if (res !== exp || z !== (exp == 32'h0)) begin
        errors++;
        $display("FAIL random_result op=%h a=%h b=%h: got %h z=%b expected %h", op, a, b, res, z, exp);
      end
      checks++;
      if (lat != el || bcnt != el - 1) begin
        errors++;
        $display("FAIL random_latency op=%h: got lat=%0d busy=%0d expected lat=%0d busy=%0d", op, lat, bcnt, el, el - 1);
      end
      checks++;
      if (!rdy0 || !drop) begin
        errors++;
        $display("FAIL random_handshake op=%h: got ready_before=%b idle_after=%b expected 1 1", op, rdy0, drop);
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = 5'h01;
    bus.a = 32'd3;
    bus.b = 32'd3;
    @(posedge clk); #1;
    bus.op = 5'h00;
    bus.a = 32'd1;
    bus.b = 32'd1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!(bus.out_valid === 1'b1 && bus.result === 32'h0 && bus.zero === 1'b1 && bus.in_ready === 1'b0)) ok = 1'b0;
      if (i < 5) begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL backpressure_hold: got ov=%b res=%h z=%b ir=%b expected 1 00000000 1 0", bus.out_valid, bus.result, bus.zero, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got ov=%b ir=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd2) begin
      errors++;
      $display("FAIL backpressure_second: got ov=%b res=%h expected 1 00000002", bus.out_valid, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res;
    logic z, rdy0, drop, seen;
    int lat, bcnt;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 5'h15;
    bus.a = $urandom | 32'h80000000;
    bus.b = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.zero} !== 4'b0101 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: got ov/ir/busy/z=%b res=%h expected 0101 00000000", {bus.out_valid, bus.in_ready, bus.busy, bus.zero}, bus.result);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_output: got out_valid=1 after abort expected 0");
    end
    run_op(5'h00, 32'd2, 32'd2, res, z, lat, bcnt, rdy0, drop);
    checks++;
    if (res !== 32'd4 || lat != 1 || !rdy0 || !drop) begin
      errors++;
      $display("FAIL abort_followup: got res=%h lat=%0d expected 00000004 lat=1", res, lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Width-parametrised, multi-cycle successor to the combinational datapath ALU.
- Covers the full base ALU/branch-compare op set plus the RV32M multiply/divide/remainder group.
- Uses valid/ready handshakes on input and output so the pipeline can stall on long operations.
- Sits in the EX stage; the hazard unit uses `busy` to freeze upstream stages.

Parameters:
- XLEN, 32: operand/result width; must be a power of two, at least 8.
- SHW, $clog2(XLEN): shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request; high only in IDLE
- op  input  5  operation code (encoding below)
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2/imm)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- zero  output  1  (result == 0), derived from the registered result
- busy  output  1  state is MUL or DIV

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); it is sampled only on the clk rising edge.
- Reset values: state = IDLE, out_valid = 0, result = 0, zero = 1, busy = 0, in_ready = 1, all iteration registers = 0.
- Operands and op are captured on the accepting edge only (in_valid && in_ready). Later changes to a, b or op have no effect.
- Op encoding 0x00–0x0F:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR.
  - 0x05 SLL, 0x06 SRL, 0x07 SRA; shift amount is b[SHW-1:0].
  - 0x08 SLT, 0x09 SLTU.
  - 0x0A/0x0B: a−b (BEQ/BNE compare).
  - 0x0C BLT, 0x0D BGE (signed); 0x0E BLTU, 0x0F BGEU (unsigned). Each yields 1 or 0.
- Op encoding 0x10–0x17:
  - 0x10 MUL (low XLEN bits), 0x11 MULH (s×s), 0x12 MULHSU (s×u), 0x13 MULHU (u×u).
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
- Op encoding 0x18–0x1F: result 0, one-cycle path.
- Arithmetic is modulo 2^XLEN. Signed ops treat bit XLEN−1 as the sign.
- States:
  - IDLE: on accept, an op below 0x10 (or a 0x18–0x1F op, or a divide fast-path case) computes its result → DONE. MUL ops → MUL. Divide ops → DIV.
  - MUL: radix-2 shift-add on operand magnitudes over a 2·XLEN accumulator, one bit per cycle, XLEN iterations. The final product is negated when the operand signs differ (per op signedness) → DONE.
  - DIV: restoring divide on magnitudes, one quotient bit per cycle, XLEN iterations. Quotient sign = sign(a) xor sign(b); remainder takes the sign of a → DONE.
  - DONE: out_valid = 1 and result is held stable. On out_ready → IDLE, and out_valid drops on the next edge.
- Latency from the accept edge to out_valid high:
  - Base ops: 1 cycle.
  - MUL/DIV: XLEN+1 cycles.
- Throughput: no new request is accepted until the DONE handshake completes. in_ready is low in MUL, DIV and DONE; there is no bypass.
- Divide fast paths (1-cycle latency):
  - b == 0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a = 2^(XLEN−1), b = all ones): DIV → a; REM → 0.
- rst asserted in any state, including mid-iteration, aborts the operation. Next edge returns to reset values; no out_valid is produced for the aborted op.
- in_valid while in_ready = 0 is ignored. The requester must hold the request until it is accepted.

Optional Feature:
- Macro: ALU_MDU_MEXT_EN.
- Defined: the MUL/DIV states and iteration datapath are compiled in; ops 0x10–0x17 behave as above.
- Undefined: the MUL and DIV states and their registers are removed. Ops 0x10–0x17 complete in 1 cycle with result 0, and busy is tied to 0.

Test Plan:
- XLEN=32. ADD a=0x7FFFFFFF, b=1, out_ready=1 → out_valid one cycle after accept; result 0x80000000; zero=0.
- SRA a=0x80000000, b=0x00000024 (shift 4) → 0xF8000000. BGEU a=1, b=0xFFFFFFFF → 0.
- MULH a=0xFFFFFFFF (−1), b=0x00000002 → 0xFFFFFFFF after 33 cycles; busy high 32 cycles. MULHU same operands → 0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU a=5, b=0 → 0xFFFFFFFF in 1 cycle. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Backpressure: out_ready=0 for 5 cycles after a SUB 3−3 → result 0 and zero=1 held stable; in_ready stays 0; a second in_valid is not accepted until the DONE handshake completes.
- Assert rst at iteration 10 of a DIVU → next cycle state IDLE, out_valid=0, result=0, in_ready=1. A following ADD 2+2 → 4 with 1-cycle latency.
